// File: rtl/msk_ctrl_pkg.sv
// Shared types and helpers for the masked-core round controller.
package msk_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ctrl_st_e;

  // $clog2 clamped to at least one bit so single-value counters still have a port.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/msk_round_cnt.sv
// Stage/round counter pair. The stage wraps explicitly at LAT-1 and the round at NROUNDS-1.
module msk_round_cnt
  import msk_ctrl_pkg::*;
#(
  parameter  int NROUNDS = 10,
  parameter  int LAT     = 2,
  localparam int RW      = clog2_min1(NROUNDS),
  localparam int SW      = clog2_min1(LAT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          adv,
  output logic          stage_last,
  output logic          round_last,
  output logic [RW-1:0] round_idx
);

  logic [SW-1:0] stage;

  assign stage_last = (stage == SW'(LAT - 1));
  assign round_last = (round_idx == RW'(NROUNDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage     <= '0;
      round_idx <= '0;
    end else if (clr) begin
      stage     <= '0;
      round_idx <= '0;
    end else if (adv) begin
      if (stage_last) begin
        stage     <= '0;
        round_idx <= round_last ? '0 : round_idx + 1'b1;
      end else begin
        stage <= stage + 1'b1;
      end
    end
  end

endmodule

// File: rtl/msk_round_ctrl.sv
// Round sequencer for an iterative masked core: accepts a job, runs NROUNDS x LAT
// advance cycles gated by fresh randomness, then holds the result until taken.
module msk_round_ctrl
  import msk_ctrl_pkg::*;
#(
  parameter  int NROUNDS = 10,
  parameter  int LAT     = 2,
  localparam int RW      = clog2_min1(NROUNDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  input  logic          rnd_valid,
  output logic          rnd_ready,
  output logic          pipe_en,
  output logic          state_en,
  output logic          state_load,
  output logic [RW-1:0] round_idx,
  output logic          last_round
);

  ctrl_st_e st;
  logic     accept, adv, stage_last, round_last;

  assign accept = (st == ST_IDLE) && in_valid;
  assign adv    = (st == ST_RUN) && rnd_valid;

  msk_round_cnt #(.NROUNDS(NROUNDS), .LAT(LAT)) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (accept),
    .adv        (adv),
    .stage_last (stage_last),
    .round_last (round_last),
    .round_idx  (round_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= ST_IDLE;
    end else begin
      case (st)
        ST_IDLE: if (in_valid) st <= ST_RUN;
        ST_RUN:  if (adv && stage_last && round_last) st <= ST_DONE;
        ST_DONE: if (out_ready) st <= ST_IDLE;
        default: st <= ST_IDLE;
      endcase
    end
  end

  // state_load is a pure IDLE decode; it only has effect together with state_en.
  assign in_ready   = (st == ST_IDLE);
  assign out_valid  = (st == ST_DONE);
  assign rnd_ready  = (st == ST_RUN);
  assign state_load = (st == ST_IDLE);
  assign last_round = (st == ST_RUN) && round_last;
  assign pipe_en    = adv;
  assign state_en   = accept || (adv && stage_last);

endmodule

// File: tb/tb_msk_round_ctrl.sv
// Self-checking bench for msk_round_ctrl: directed timing scenarios plus randomized jobs.
module tb_msk_round_ctrl;
  localparam int NR = 10, LT = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic iv, ir, ov, ordy, rv, rr, pe, se, sl, lr;
  logic [3:0] ri;
  logic iv1, ir1, ov1, ordy1, rv1, rr1, pe1, se1, sl1, lr1;
  logic [0:0] ri1;

  int checks = 0, failures = 0;

  msk_round_ctrl #(.NROUNDS(NR), .LAT(LT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .out_valid(ov), .out_ready(ordy),
    .rnd_valid(rv), .rnd_ready(rr), .pipe_en(pe), .state_en(se), .state_load(sl),
    .round_idx(ri), .last_round(lr)
  );

  msk_round_ctrl #(.NROUNDS(1), .LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .out_valid(ov1), .out_ready(ordy1),
    .rnd_valid(rv1), .rnd_ready(rr1), .pipe_en(pe1), .state_en(se1), .state_load(sl1),
    .round_idx(ri1), .last_round(lr1)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // bundle {ir,ov,rr,pe,se,lr,ri}
  task automatic test_reset();
    rst_n = 1'b0; iv = 0; rv = 0; ordy = 0; iv1 = 0; rv1 = 0; ordy1 = 0;
    #2;
    checks++;
    if ({ir, ov, rr, pe, se, lr, ri} !== {6'b100000, 4'd0}) begin
      failures++; $display("FAIL reset_outputs got=%b exp=%b", {ir, ov, rr, pe, se, lr, ri}, {6'b100000, 4'd0});
    end
    checks++;
    if ({ir1, ov1, rr1, pe1, se1, lr1, ri1} !== 7'b1000000) begin
      failures++; $display("FAIL reset_outputs_1x1 got=%b exp=%b", {ir1, ov1, rr1, pe1, se1, lr1, ri1}, 7'b1000000);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({ir, ov, se} !== 3'b100) begin
      failures++; $display("FAIL post_reset_idle got=%b exp=100", {ir, ov, se});
    end
  endtask

  task automatic test_single();
    iv1 = 1; rv1 = 1; #1;
    checks++;
    if ({ir1, se1, sl1, pe1} !== 4'b1110) begin
      failures++; $display("FAIL single_accept got=%b exp=1110", {ir1, se1, sl1, pe1});
    end
    tick(); iv1 = 0; #1;
    checks++;
    if ({se1, lr1, pe1, ov1, sl1} !== 5'b11100) begin
      failures++; $display("FAIL single_round got=%b exp=11100", {se1, lr1, pe1, ov1, sl1});
    end
    tick(); #1;
    checks++;
    if ({ov1, se1, rr1, ir1} !== 4'b1000) begin
      failures++; $display("FAIL single_done got=%b exp=1000", {ov1, se1, rr1, ir1});
    end
    ordy1 = 1; tick(); ordy1 = 0; #1;
    checks++;
    if ({ir1, ov1} !== 2'b10) begin
      failures++; $display("FAIL single_handoff got=%b exp=10", {ir1, ov1});
    end
  endtask

  task automatic test_nominal();
    logic [9:0] exp;
    iv = 1; rv = 1; ordy = 0; #1;
    checks++;
    if ({ir, se, sl, pe, ov} !== 5'b11100) begin
      failures++; $display("FAIL nominal_accept got=%b exp=11100", {ir, se, sl, pe, ov});
    end
    for (int c = 1; c <= 21; c++) begin
      tick(); iv = 0; #1;
      exp = {1'b0, (c == 21), (c <= 20), (c <= 20), (c <= 20 && c % 2 == 0),
             (c >= 19 && c <= 20), (c <= 20) ? 4'((c - 1) / 2) : 4'd0};
      checks++;
      if ({ir, ov, rr, pe, se, lr, ri} !== exp) begin
        failures++; $display("FAIL nominal cycle=%0d got=%b exp=%b", c, {ir, ov, rr, pe, se, lr, ri}, exp);
      end
    end
    ordy = 1; tick(); ordy = 0; #1;
    checks++;
    if ({ir, ov} !== 2'b10) begin
      failures++; $display("FAIL nominal_handoff got=%b exp=10", {ir, ov});
    end
  endtask

  task automatic test_stall();
    logic [9:0] exp;
    int adv = 0;
    iv = 1; rv = 1; #1;
    checks++;
    if ({ir, se, sl} !== 3'b111) begin
      failures++; $display("FAIL stall_accept got=%b exp=111", {ir, se, sl});
    end
    for (int c = 1; c <= 24; c++) begin
      tick(); iv = 0; rv = !(c >= 5 && c <= 7); #1;
      if (adv < NR * LT)
        exp = {1'b0, 1'b0, 1'b1, rv, rv && (adv % LT == LT - 1), (adv / LT == NR - 1), 4'(adv / LT)};
      else
        exp = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
      checks++;
      if ({ir, ov, rr, pe, se, lr, ri} !== exp) begin
        failures++; $display("FAIL stall cycle=%0d got=%b exp=%b", c, {ir, ov, rr, pe, se, lr, ri}, exp);
      end
      if (adv < NR * LT && rv) adv++;
    end
    rv = 1;
  endtask

  task automatic test_done_hold();
    iv = 1; ordy = 0;
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      checks++;
      if ({ov, ir, se, pe} !== 4'b1000) begin
        failures++; $display("FAIL done_hold k=%0d got=%b exp=1000", k, {ov, ir, se, pe});
      end
    end
    tick(); ordy = 1; #1;
    checks++;
    if ({ov, ir, se} !== 3'b100) begin
      failures++; $display("FAIL done_release got=%b exp=100", {ov, ir, se});
    end
    tick(); ordy = 0; #1;
    checks++;
    if ({ir, se, sl, ov} !== 4'b1110) begin
      failures++; $display("FAIL done_reaccept got=%b exp=1110", {ir, se, sl, ov});
    end
  endtask

  task automatic test_reset_mid();
    int n = 0, seen = 0;
    tick(); iv = 0; rv = 1; #1;
    while (ri !== 4'd5 && n < 40) begin
      tick(); #1; n++;
    end
    checks++;
    if (n >= 40) begin
      failures++; $display("FAIL reset_mid_reach_round5 got=%0d exp=5", ri);
    end
    rst_n = 1'b0; #1;
    checks++;
    if ({ir, pe, se, ov, ri} !== {4'b1000, 4'd0}) begin
      failures++; $display("FAIL reset_mid got=%b exp=%b", {ir, pe, se, ov, ri}, {4'b1000, 4'd0});
    end
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick(); #1;
      if (ov === 1'b1 || ir !== 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++; $display("FAIL reset_mid_dropped got=%0d bad_cycles exp=0", seen);
    end
  endtask

  task automatic test_random();
    logic [9:0] exp;
    for (int j = 0; j < 1000; j++) begin
      int adv = 0, n = 0, err = 0, rng_err = 0, pe_cnt = 0;
      int gap = $urandom_range(0, 2), hold = $urandom_range(0, 3), pct = $urandom_range(1, 3);
      for (int g = 0; g < gap; g++) begin
        iv = 0; rv = $urandom_range(0, 1); #1;
        if ({ir, se, pe} !== 3'b100) err++;
        tick();
      end
      iv = 1; rv = $urandom_range(0, 1); #1;
      if ({ir, se, sl, pe} !== 4'b1110) err++;
      tick(); iv = 0;
      while (adv < NR * LT && n < 400) begin
        rv = ($urandom_range(0, 3) < pct); #1;
        exp = {1'b0, 1'b0, 1'b1, rv, rv && (adv % LT == LT - 1), (adv / LT == NR - 1), 4'(adv / LT)};
        if ({ir, ov, rr, pe, se, lr, ri} !== exp) err++;
        if (ri >= NR) rng_err++;
        if (pe === 1'b1) pe_cnt++;
        if (rv) adv++;
        tick(); n++;
      end
      rv = $urandom_range(0, 1); #1;
      checks++;
      if (ov !== 1'b1 || adv != NR * LT) begin
        failures++; $display("FAIL rand_done job=%0d got=%b adv=%0d exp=1 adv=%0d", j, ov, adv, NR * LT);
      end
      for (int h = 0; h < hold; h++) begin
        if ({ov, ir, se, pe, rr} !== 5'b10000) err++;
        tick(); iv = $urandom_range(0, 1); #1;
      end
      if ({ov, ir} !== 2'b10) err++;
      ordy = 1; tick(); ordy = 0; iv = 0;
      checks++;
      if (pe_cnt != NR * LT) begin
        failures++; $display("FAIL rand_adv_count job=%0d got=%0d exp=%0d", j, pe_cnt, NR * LT);
      end
      checks++;
      if (rng_err != 0) begin
        failures++; $display("FAIL rand_round_range job=%0d got=%0d exp=0", j, rng_err);
      end
      checks++;
      if (err != 0) begin
        failures++; $display("FAIL rand_model job=%0d got=%0d bad_cycles exp=0", j, err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_nominal();
    test_stall();
    test_done_hold();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
